mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to en_ram_out; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_ram_in  input  1  fetch request strobe from the control unit.
REQ-006 SHALL have port addr  input  ADDR_W  fetch address (PC), sampled when the request is accepted.
REQ-007 SHALL have port ins  output  16  fetched instruction word.
REQ-008 SHALL have port en_ram_out  output  1  one-cycle pulse marking ins valid.
REQ-009 SHALL have ports ld_we (input, 1), ld_addr (input, ADDR_W) and ld_data (input, 16), forming the program-load write port.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port req_drop  output  1  sticky flag, set when a request is lost.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP, plus a 4-bit latency counter and a 1-entry pending slot holding a valid bit and an address.
REQ-013 In IDLE, en_ram_in=1 SHALL accept the request: latch addr, load counter with LATENCY-1, go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-014 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the cycle the counter reaches 0.
REQ-015 In RESP, en_ram_out SHALL be 1 for exactly one cycle with ins = mem[latched addr].
REQ-016 Request accepted at cycle T SHALL produce en_ram_out at cycle T+LATENCY.
REQ-017 ins SHALL hold its last value until the next RESP.
REQ-018 Exit from RESP: a valid pending slot SHALL be accepted first (slot cleared); else en_ram_in=1 in that cycle SHALL be accepted; else the FSM SHALL go to IDLE.
REQ-019 If RESP accepts the pending slot while en_ram_in=1 in the same cycle, the new request SHALL enter the slot.
REQ-020 en_ram_in=1 in WAIT SHALL fill the pending slot if empty; if the slot is full, the request SHALL be dropped and req_drop set.
REQ-021 ld_we=1 SHALL write ld_data to mem[ld_addr] at the clock edge; writes are legal in every state.
REQ-022 A write and a RESP read to the same address in the same cycle SHALL return ld_data (write-first forwarding).
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 Out-of-range addresses cannot occur, because all addresses are ADDR_W bits wide and wrap naturally.

Reset
REQ-025 rst low SHALL asynchronously force: FSM=IDLE, counter=0, pending slot empty, ins=16'h0000, en_ram_out=0, busy=0, req_drop=0.
REQ-026 Reset asserted mid-WAIT or mid-RESP SHALL abort the transfer; no en_ram_out pulse for that transfer after release.
REQ-027 req_drop SHALL clear only on reset.

Configuration
REQ-028 Macro LD_LOCK_EN, when defined, SHALL add input ld_lock (1) and output ld_err (1).
REQ-029 With LD_LOCK_EN: ld_lock=1 SHALL set a lock latch held until reset; while locked, ld_we SHALL be ignored and ld_err pulses for one cycle per attempted write.
REQ-030 Without LD_LOCK_EN: the ports SHALL be absent and writes SHALL always be accepted.

Structure
REQ-031 FSM state encoding and the LATENCY range limit SHALL live in a shared package, tinylab_pkg.
REQ-032 The storage array with write-first forwarding SHALL be a sub-module, mem_array.

Verification
REQ-033 Load mem[0x05]=16'h1A2B; request addr 0x05 at cycle T with LATENCY=2 -> en_ram_out=1 at T+2, ins=16'h1A2B, busy 1 for T+1..T+2.
REQ-034 Back-to-back: request 0x00 at T and request 0x01 in the RESP cycle (T+2) -> pulses at T+2 and T+4 with the correct words; req_drop=0.
REQ-035 Two requests during WAIT -> first served after the current transfer, second dropped; req_drop=1 and remains 1 until rst.
REQ-036 ld_we to 0x10 with data 16'hBEEF in the same cycle RESP reads 0x10 -> ins=16'hBEEF.
REQ-037 rst pulsed low during WAIT -> outputs immediately 0, no en_ram_out after release, the next request is served normally.
REQ-038 With LD_LOCK_EN: ld_lock pulse, then ld_we to 0x02 -> mem[0x02] unchanged and ld_err pulses once.

Source files
------------

// File: rtl/tinylab_pkg.sv
// rtl/tinylab_pkg.sv - shared FSM encoding and latency limits for the fetch responder
package tinylab_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - instruction storage with one write port and a write-first forwarded read
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Contents survive reset so a loaded program outlives a core restart.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-programmable instruction fetch responder; LD_LOCK_EN adds a load-port lock
module mem_responder
   import tinylab_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_ram_in,
   input  logic [ADDR_W-1:0] addr,
   output logic [15:0]       ins,
   output logic              en_ram_out,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [15:0]       ld_data,
`ifdef LD_LOCK_EN
   input  logic              ld_lock,
   output logic              ld_err,
`endif
   output logic              busy,
   output logic              req_drop
);

   // Out-of-range LATENCY values are clamped into the legal window.
   localparam int LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                            (LATENCY < LATENCY_MIN) ? LATENCY_MIN : LATENCY;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam state_t           START_ST = (CNT_LOAD == '0) ? ST_RESP : ST_WAIT;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
   logic              pend_v, pend_v_nx;
   logic [ADDR_W-1:0] pend_a, pend_a_nx;
   logic              drop_nx;
   logic [15:0]       ins_q;
   logic [15:0]       rd_data;
   logic              wr_en;

`ifdef LD_LOCK_EN
   logic locked;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         locked <= 1'b0;
      end else if (ld_lock) begin
         locked <= 1'b1;
      end
   end

   assign wr_en  = ld_we & ~locked;
   assign ld_err = ld_we & locked;
`else
   assign wr_en  = ld_we;
`endif

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (16)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (cur_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      cur_addr_nx = cur_addr;
      pend_v_nx   = pend_v;
      pend_a_nx   = pend_a;
      drop_nx     = req_drop;
      unique case (state)
         ST_IDLE: begin
            if (en_ram_in) begin
               cur_addr_nx = addr;
               cnt_nx      = CNT_LOAD;
               state_nx    = START_ST;
            end
         end
         ST_WAIT: begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_nx = ST_RESP;
            end
            if (en_ram_in) begin
               if (!pend_v) begin
                  pend_v_nx = 1'b1;
                  pend_a_nx = addr;
               end else begin
                  drop_nx = 1'b1;
               end
            end
         end
         ST_RESP: begin
            // The parked request has priority; a same-cycle strobe takes its place in the slot.
            if (pend_v) begin
               cur_addr_nx = pend_a;
               cnt_nx      = CNT_LOAD;
               state_nx    = START_ST;
               pend_v_nx   = en_ram_in;
               if (en_ram_in) begin
                  pend_a_nx = addr;
               end
            end else if (en_ram_in) begin
               cur_addr_nx = addr;
               cnt_nx      = CNT_LOAD;
               state_nx    = START_ST;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur_addr <= '0;
         pend_v   <= 1'b0;
         pend_a   <= '0;
         req_drop <= 1'b0;
         ins_q    <= 16'h0000;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         cur_addr <= cur_addr_nx;
         pend_v   <= pend_v_nx;
         pend_a   <= pend_a_nx;
         req_drop <= drop_nx;
         if (state == ST_RESP) begin
            ins_q <= rd_data;
         end
      end
   end

   // ins shows the live read during RESP and the held word otherwise.
   assign en_ram_out = (state == ST_RESP);
   assign busy       = (state != ST_IDLE);
   assign ins        = en_ram_out ? rd_data : ins_q;

endmodule
